// File: rtl/tbus_mem_responder.sv
// tbus_mem_responder: responder end of the trinity bus. Accepts one request
// at a time, executes it against an internal 64-bit-wide array after a fixed
// latency, then pulses tbus_operation_done for one cycle.
module tbus_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tbus_index_valid,
    output logic        tbus_index_ready,
    input  logic [63:0] tbus_index,
    input  logic [63:0] tbus_write_data,
    input  logic [63:0] tbus_write_mask,
    input  logic [1:0]  tbus_operation_type,
    output logic [63:0] tbus_read_data,
    output logic        tbus_operation_done,
    output logic        resp_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   word_q, word_d;
    logic [63:0]             writeData_q, writeData_d;
    logic [63:0]             writeMask_q, writeMask_d;
    logic [1:0]              opType_q, opType_d;
    logic [63:0]             readData_q, readData_d;
    logic                    memWrite;
    logic [63:0]             memWord;
    logic [63:0]             mergedWord;

    logic [63:0] mem [0:(2**DEPTH_LOG2)-1];

    // Byte-offset bits and upper address bits never select anything; the
    // array simply aliases modulo its size.
    logic unusedIndexBits;
    assign unusedIndexBits = ^{tbus_index[63:DEPTH_LOG2+3], tbus_index[2:0]};

    assign memWord    = mem[word_q];
    assign mergedWord = (memWord & ~writeMask_q) | (writeData_q & writeMask_q);

    // Handshake and status outputs come straight from the state register.
    assign tbus_index_ready    = (state_q == IDLE);
    assign tbus_operation_done = (state_q == DONE);
    assign resp_busy           = (state_q != IDLE);
    assign tbus_read_data      = readData_q;

    // Next-state logic: capture the request in IDLE, count down in BUSY and
    // execute when the counter reaches zero, then spend one cycle in DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        writeData_d = writeData_q;
        writeMask_d = writeMask_q;
        opType_d    = opType_q;
        readData_d  = readData_q;
        memWrite    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tbus_index_valid) begin
                    word_d      = tbus_index[DEPTH_LOG2+2:3];
                    writeData_d = tbus_write_data;
                    writeMask_d = tbus_write_mask;
                    opType_d    = tbus_operation_type;
                    cnt_d       = CNT_LOAD;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    case (opType_q)
                        OP_READ:  readData_d = memWord;
                        OP_WRITE: begin
                            readData_d = mergedWord;
                            memWrite   = 1'b1;
                        end
                        default:  readData_d = 64'd0;
                    endcase
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers; reset abandons any request in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            word_q      <= '0;
            writeData_q <= 64'd0;
            writeMask_q <= 64'd0;
            opType_q    <= 2'b00;
            readData_q  <= 64'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            writeData_q <= writeData_d;
            writeMask_q <= writeMask_d;
            opType_q    <= opType_d;
            readData_q  <= readData_d;
        end
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (memWrite) begin
            mem[word_q] <= mergedWord;
        end
    end

endmodule

// File: tb/tb_tbus_mem_responder.sv
// Bench for tbus_mem_responder: two instances (LATENCY 2 and 4) share one
// stimulus stream and are compared every cycle against an edge-count model.
module tb_tbus_mem_responder;

    localparam int DL = 4;
    localparam int NW = 1 << DL;

    logic        clock;
    logic        reset_n;
    logic        valid;
    logic [63:0] idx;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic [1:0]  opType;
    logic [1:0]  rdyV, dnV, bsyV;
    logic [63:0] rd0, rd1;

    int total = 0;
    int bad   = 0;
    bit checkOn = 0;

    tbus_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(2)) dutLat2 (
        .clock(clock), .reset_n(reset_n),
        .tbus_index_valid(valid), .tbus_index_ready(rdyV[0]),
        .tbus_index(idx), .tbus_write_data(wdata), .tbus_write_mask(wmask),
        .tbus_operation_type(opType), .tbus_read_data(rd0),
        .tbus_operation_done(dnV[0]), .resp_busy(bsyV[0])
    );

    tbus_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(4)) dutLat4 (
        .clock(clock), .reset_n(reset_n),
        .tbus_index_valid(valid), .tbus_index_ready(rdyV[1]),
        .tbus_index(idx), .tbus_write_data(wdata), .tbus_write_mask(wmask),
        .tbus_operation_type(opType), .tbus_read_data(rd1),
        .tbus_operation_done(dnV[1]), .resp_busy(bsyV[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int latOf(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    // Model: each instance is described by the edge at which it last accepted
    // a request and whether that request has executed yet.
    int          edgeCnt = 0;
    int          lastAcc [2];
    bit          pend    [2];
    logic [63:0] capIdx  [2];
    logic [63:0] capData [2];
    logic [63:0] capMask [2];
    logic [1:0]  capType [2];
    logic [63:0] mm      [2][NW];
    logic [63:0] kb      [2][NW];
    logic [63:0] expRd   [2];
    logic [63:0] expKnown[2];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reset drops anything pending and zeroes the read-data register.
    always @(negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            lastAcc[i]  = -1000;
            pend[i]     = 1'b0;
            expRd[i]    = 64'd0;
            expKnown[i] = '1;
        end
    end

    // Advance the model at every rising edge.
    always @(posedge clock) begin
        int w;
        edgeCnt++;
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && edgeCnt == lastAcc[i] + latOf(i)) begin
                    pend[i] = 1'b0;
                    w = int'(capIdx[i][DL+2:3]);
                    if (capType[i] == 2'b00) begin
                        expRd[i]    = mm[i][w];
                        expKnown[i] = kb[i][w];
                    end else if (capType[i] == 2'b01) begin
                        mm[i][w]    = (mm[i][w] & ~capMask[i]) | (capData[i] & capMask[i]);
                        kb[i][w]    = kb[i][w] | capMask[i];
                        expRd[i]    = mm[i][w];
                        expKnown[i] = kb[i][w];
                    end else begin
                        expRd[i]    = 64'd0;
                        expKnown[i] = '1;
                    end
                end else if (!pend[i] && (edgeCnt - 1 >= lastAcc[i] + latOf(i) + 1) && valid) begin
                    lastAcc[i] = edgeCnt;
                    pend[i]    = 1'b1;
                    capIdx[i]  = idx;
                    capData[i] = wdata;
                    capMask[i] = wmask;
                    capType[i] = opType;
                end
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clock) begin
        bit er, ed;
        if (checkOn) begin
            for (int i = 0; i < 2; i++) begin
                er = !pend[i] && (edgeCnt >= lastAcc[i] + latOf(i) + 1);
                ed = !pend[i] && (edgeCnt == lastAcc[i] + latOf(i));
                checkOutput(i == 0 ? "ready_l2" : "ready_l4", 64'(rdyV[i]), 64'(er));
                checkOutput(i == 0 ? "done_l2"  : "done_l4",  64'(dnV[i]),  64'(ed));
                checkOutput(i == 0 ? "busy_l2"  : "busy_l4",  64'(bsyV[i]), 64'(!er));
                checkOutput(i == 0 ? "rdata_l2" : "rdata_l4",
                            (i == 0 ? rd0 : rd1) & expKnown[i], expRd[i] & expKnown[i]);
            end
        end
    end

    // Wait (bounded) until both instances are idle, ending on a falling edge.
    task automatic waitIdle();
        @(negedge clock);
        for (int k = 0; k < 30 && rdyV != 2'b11; k++) @(negedge clock);
        checkOutput("idleWait", 64'(rdyV), 64'(2'b11));
    endtask

    // Present one request for a single cycle so both instances accept together.
    task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a,
                                 input logic [63:0] d, input logic [63:0] m);
        waitIdle();
        opType = op;
        idx    = a;
        wdata  = d;
        wmask  = m;
        valid  = 1'b1;
        @(negedge clock);
        valid  = 1'b0;
    endtask

    // Starting in the cycle after acceptance, measure done latency per instance.
    task automatic waitDone(input string tag, input bit chkRd, input logic [63:0] expV);
        int got [2];
        got[0] = -1;
        got[1] = -1;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 2; i++) if (dnV[i] && got[i] < 0) got[i] = k;
            if (got[0] >= 0 && got[1] >= 0) break;
            @(negedge clock);
        end
        checkOutput({tag, "_lat2"}, 64'(got[0]), 64'd2);
        checkOutput({tag, "_lat4"}, 64'(got[1]), 64'd4);
        if (chkRd) begin
            checkOutput({tag, "_rd2"}, rd0, expV);
            checkOutput({tag, "_rd4"}, rd1, expV);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [1:0] bpExp [7];

    initial begin
        valid   = 1'b0;
        idx     = 64'd0;
        wdata   = 64'd0;
        wmask   = 64'd0;
        opType  = 2'b00;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < NW; w++) begin
                mm[i][w] = 64'd0;
                kb[i][w] = 64'd0;
            end
        end
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        checkOn = 1'b1;
        $display("[TB] reset released");
        checkOutput("rstReady", 64'(rdyV), 64'(2'b11));
        checkOutput("rstDone",  64'(dnV),  64'(2'b00));
        checkOutput("rstBusy",  64'(bsyV), 64'(2'b00));
        checkOutput("rstRd",    rd0 | rd1, 64'd0);

        // Full write then reads of the same word at two byte offsets.
        applyStimulus(2'b01, 64'h40, 64'h1122334455667788, '1);
        waitDone("wr40", 1'b1, 64'h1122334455667788);
        applyStimulus(2'b00, 64'h40, 64'h0, 64'h0);
        waitDone("rd40", 1'b1, 64'h1122334455667788);
        applyStimulus(2'b00, 64'h47, 64'h0, 64'h0);
        waitDone("rd47", 1'b1, 64'h1122334455667788);

        // Masked write clears only byte 1.
        applyStimulus(2'b01, 64'h80, '1, '1);
        waitDone("pre80", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(2'b01, 64'h80, 64'h0, 64'h0000_0000_0000_FF00);
        waitDone("mask80", 1'b1, 64'hFFFF_FFFF_FFFF_00FF);
        applyStimulus(2'b00, 64'h80, 64'h0, 64'h0);
        waitDone("rd80", 1'b1, 64'hFFFF_FFFF_FFFF_00FF);

        // Backpressure: valid held high, request contents change while busy.
        bpExp = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        waitIdle();
        opType = 2'b01;
        idx    = 64'h30;
        wdata  = 64'hA0A1A2A3A4A5A6A7;
        wmask  = '1;
        valid  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            checkOutput($sformatf("bpReady%0d", k), 64'(rdyV), 64'(bpExp[k]));
            if (k == 0) begin
                idx   = 64'h38;
                wdata = 64'hB0B1B2B3B4B5B6B7;
            end
        end
        valid = 1'b0;
        applyStimulus(2'b00, 64'h30, 64'h0, 64'h0);
        waitDone("bpRd30", 1'b1, 64'hA0A1A2A3A4A5A6A7);
        applyStimulus(2'b00, 64'h38, 64'h0, 64'h0);
        waitDone("bpRd38", 1'b1, 64'hB0B1B2B3B4B5B6B7);

        // Reserved type leaves the array alone and returns zero.
        applyStimulus(2'b10, 64'h40, 64'hDEAD_BEEF_DEAD_BEEF, '1);
        waitDone("rsv", 1'b1, 64'h0);
        applyStimulus(2'b00, 64'h40, 64'h0, 64'h0);
        waitDone("rsvRd", 1'b1, 64'h1122334455667788);

        // Upper address bits alias onto the same word.
        applyStimulus(2'b01, 64'h08 + (64'd8 << DL), 64'hC3C3_5A5A_0F0F_9696, '1);
        waitDone("aliasWr", 1'b1, 64'hC3C3_5A5A_0F0F_9696);
        applyStimulus(2'b00, 64'h08, 64'h0, 64'h0);
        waitDone("aliasRd", 1'b1, 64'hC3C3_5A5A_0F0F_9696);

        // Reset while a write is still counting down.
        applyStimulus(2'b01, 64'h20, 64'h0123_4567_89AB_CDEF, '1);
        waitDone("pre20", 1'b1, 64'h0123_4567_89AB_CDEF);
        waitIdle();
        opType = 2'b01;
        idx    = 64'h20;
        wdata  = 64'hFEDC_BA98_7654_3210;
        wmask  = '1;
        valid  = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncReady", 64'(rdyV), 64'(2'b11));
        checkOutput("asyncDone",  64'(dnV),  64'(2'b00));
        checkOutput("asyncBusy",  64'(bsyV), 64'(2'b00));
        checkOutput("asyncRd",    rd0 | rd1, 64'd0);
        opType = 2'b00;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        valid = 1'b0;
        checkOutput("rstAccept", 64'(rdyV), 64'(2'b00));
        waitDone("rstRd20", 1'b1, 64'h0123_4567_89AB_CDEF);

        // Randomized traffic with inputs changing every cycle.
        for (int c = 0; c < 600; c++) begin
            int r;
            @(negedge clock);
            valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            opType = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : 2'($urandom_range(2, 3));
            idx   = {$urandom(), $urandom()};
            wdata = {$urandom(), $urandom()};
            case ($urandom_range(0, 2))
                0:       wmask = '1;
                1:       wmask = 64'h00FF_00FF_FF00_FF00;
                default: wmask = {$urandom(), $urandom()};
            endcase
        end
        @(negedge clock);
        valid = 1'b0;
        repeat (10) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tbus_mem_responder.md
# tbus_mem_responder

Responder (slave) end of the trinity bus (tbus). It accepts one request at a time from the LSU/D$ initiator and executes it against an internal 64-bit-wide memory array after a fixed, programmable latency. It answers with a one-cycle `tbus_operation_done` pulse and, for reads, `tbus_read_data`. It serves as the backing store behind the backend memory stage in simulation and in small SoC builds.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: log2 of the number of 64-bit words in the array.
- `LATENCY`, default 2: clock edges from request acceptance to the `done` pulse. Legal range is 1..15.

Ports:
- `clock`  in  1: single clock. Everything is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `tbus_index_valid`  in  1: the initiator presents a request.
- `tbus_index_ready`  out  1: the responder can accept a request this cycle.
- `tbus_index`  in  64: byte address.
- `tbus_write_data`  in  64: store data.
- `tbus_write_mask`  in  64: per-bit write enable. A 1 means the bit is written.
- `tbus_operation_type`  in  2: operation code. 2'b00 = read, 2'b01 = write, 2'b10/2'b11 = reserved.
- `tbus_read_data`  out  64: read result.
- `tbus_operation_done`  out  1: one-cycle completion pulse.
- `resp_busy`  out  1: a request is in flight (debug/perf).

## Operation
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE: `tbus_index_ready` = 1. If `tbus_index_valid` is high, the request is accepted. Accepting registers index, data, mask and type, loads `cnt` = LATENCY-1 and moves to BUSY.
  - BUSY: `ready` = 0. If `cnt` != 0, decrement it. If `cnt` == 0, execute the request and move to DONE.
  - DONE: `tbus_operation_done` = 1, `ready` = 0. Move unconditionally to IDLE on the next edge.
- Word select is `idx[DEPTH_LOG2+2:3]`.
  - Bits [2:0] are ignored. Reads return the full aligned 64-bit word; the initiator extracts and extends bytes.
  - Upper address bits are ignored, so addresses alias modulo 8·2^DEPTH_LOG2 bytes.
- Read execute: `tbus_read_data` <= mem[word].
- Write execute: mem[word] <= (mem[word] & ~mask) | (data & mask). `tbus_read_data` <= the post-write word.
- Reserved type: no array write, `tbus_read_data` <= 0, and `done` still pulses. The bus must never hang.
- `tbus_read_data` holds its value from DONE until the next execute.
- Inputs are sampled only on the acceptance edge. Changes to the initiator's data, mask or type while BUSY have no effect.
- `resp_busy` = (state != IDLE).
- The array is not reset; the contents are undefined until written.

## Timing
- Reset values: state = IDLE, `tbus_index_ready` = 1, `tbus_operation_done` = 0, `tbus_read_data` = 0, `resp_busy` = 0, `cnt` = 0.
- `ready`, `done` and `resp_busy` are decoded directly from registered state, with no combinational path from inputs.
- Acceptance happens at the edge where `valid` & `ready` are both high.
- If acceptance is at edge N, `done` is high for the cycle between edge N+LATENCY and edge N+LATENCY+1. The read data is valid in that same cycle.
- The next acceptance can occur at edge N+LATENCY+2 at the earliest. The sustained rate is one request per LATENCY+2 cycles.
- If `valid` is high while `ready` is low, the request is not accepted. The initiator holds its request, and acceptance happens at the first IDLE edge.
- Reset asserted mid-operation: the FSM returns to IDLE asynchronously and `done` is not pulsed.
  - A write not yet executed is dropped.
  - A write already executed remains in the array.
- LATENCY=1: BUSY lasts one cycle with `cnt` = 0; `done` is high in the cycle between edge N+1 and edge N+2.

## Test plan
- Reset and ready: assert `reset_n`=0 for 3 cycles, release -> `ready`=1, `done`=0, `read_data`=0, `busy`=0. Pull `reset_n` low asynchronously between edges -> outputs return to their reset values immediately.
- Full write then read, LATENCY=2: write idx=0x40, data=0x1122334455667788, mask=all-ones.
  - `done` pulses exactly 2 edges after acceptance.
  - Reading idx=0x40 returns 0x1122334455667788.
  - Reading idx=0x47 returns the same word.
- Masked write: preload word 0x80 with 0xFFFF_FFFF_FFFF_FFFF, then write data=0, mask=0x0000_0000_0000_FF00. A read returns 0xFFFF_FFFF_FFFF_00FF.
- Backpressure and input hold: keep `valid` high continuously and change the data while BUSY.
  - `ready`=0 from the acceptance edge until IDLE.
  - The second request is accepted at edge N+LATENCY+2.
  - The first write uses only the data sampled at its acceptance edge.
- Reserved type and aliasing: a request with type=2'b10 gives `done` after LATENCY edges, `read_data`=0, and no array change. Write idx=0x08 + (8<<DEPTH_LOG2), then read idx=0x08 -> returns the written value.
- Reset mid-BUSY with LATENCY=4: assert reset 2 cycles after accepting a write.
  - No `done` pulse occurs.
  - Word content is unchanged, as checked by a read after reset.
  - The FSM accepts a new request on the first edge after reset release.
